ws2812_frame_sender: RTL

- Parametrised WS2812B strip driver: streams NUM_LEDS independent 24-bit GRB pixels from an external synchronous pixel RAM.
- Each bit is NZR-encoded with cycle-accurate high/low timing, followed by a >280 us reset code.
- Successor to the fixed-length, single-colour sender. Adds per-LED colour, run-time-independent timing parameters, seamless pixel prefetch (no inter-LED gaps) and an abort path.
- Sits between the game engines (which write pixel RAM and pulse start) and the strip pin.

---
 rtl/ws2812_frame_sender.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_sender.sv
// ws2812_frame_sender: streams NUM_LEDS 24-bit GRB pixels from a synchronous
// pixel RAM to a WS2812B strip as back-to-back NZR bits, then a low reset code.
// The next pixel is prefetched during bit 23 of the current LED, so bit periods
// run contiguously across the whole frame.
// Optional: define WS2812_BRIGHTNESS_EN to add a brightness[7:0] input. Each
// channel is then scaled as (c*(brightness+1))>>8 when a pixel is captured.
module ws2812_frame_sender #(
    parameter int NUM_LEDS  = 5,
    parameter int ADDR_W    = 8,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 15000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    input  logic [23:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              data_out,
    output logic              ready,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(BIT_CYC);
    localparam int RST_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0]  T0H_C     = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0]  T1H_C     = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0]  HOLD_CNT  = CNT_W'(2);
    localparam logic [RST_W-1:0]  RCNT_LAST = RST_W'(RESET_CYC - 1);
    localparam logic [ADDR_W-1:0] LED_LAST  = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        RESET_CODE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [ADDR_W-1:0] led_q, led_d;
    logic [23:0]       shift_q, shift_d;
    logic [23:0]       hold_q, hold_d;
    logic [RST_W-1:0]  rcnt_q, rcnt_d;
    logic              tail_q, tail_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              data_out_q, data_out_d;
    logic              ready_q, ready_d;
    logic              frame_done_q, frame_done_d;
    logic [23:0]       cap_word;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * 16'({1'b0, b} + 9'd1);
        return p[15:8];
    endfunction

    // Pixel as it will be captured: each channel scaled by the live brightness.
    always_comb begin
        cap_word = {scale(pix_data[23:16], brightness),
                    scale(pix_data[15:8],  brightness),
                    scale(pix_data[7:0],   brightness)};
    end
`else
    // Pixel as it will be captured: raw RAM word.
    always_comb begin
        cap_word = pix_data;
    end
`endif

    // Next-state logic for the frame FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        led_d        = led_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        rcnt_d       = rcnt_q;
        tail_d       = tail_q;
        pix_addr_d   = pix_addr_q;
        data_out_d   = data_out_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_out_d = 1'b0;
                if (start) begin
                    ready_d    = 1'b0;
                    pix_addr_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d    = RESET_CODE;
                    data_out_d = 1'b0;
                    rcnt_d     = '0;
                    tail_d     = 1'b0;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d    = RESET_CODE;
                    data_out_d = 1'b0;
                    rcnt_d     = '0;
                    tail_d     = 1'b0;
                end else begin
                    shift_d = cap_word;
                    bit_d   = 5'd23;
                    led_d   = '0;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    // Abort wins over every counter advance in this clock.
                    state_d    = RESET_CODE;
                    data_out_d = 1'b0;
                    rcnt_d     = '0;
                    tail_d     = 1'b0;
                    cnt_d      = '0;
                end else begin
                    data_out_d = (cnt_q < (shift_q[23] ? T1H_C : T0H_C));
                    // Prefetch: address out at the first clock of bit 23, data
                    // back from the RAM two clocks later.
                    if (bit_q == 5'd23 && led_q != LED_LAST) begin
                        if (cnt_q == '0)
                            pix_addr_d = led_q + 1'b1;
                        if (cnt_q == HOLD_CNT)
                            hold_d = cap_word;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (bit_q == 5'd0) begin
                            if (led_q == LED_LAST) begin
                                state_d = RESET_CODE;
                                rcnt_d  = '0;
                                tail_d  = 1'b1;
                            end else begin
                                led_d   = led_q + 1'b1;
                                bit_d   = 5'd23;
                                shift_d = hold_q;
                            end
                        end else begin
                            bit_d   = bit_q - 5'd1;
                            shift_d = {shift_q[22:0], 1'b0};
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESET_CODE: begin
                data_out_d = 1'b0;
                // After a natural end the pin still carries the last bit's low
                // tail for one clock; the reset code proper starts after it.
                if (tail_q) begin
                    tail_d = 1'b0;
                end else if (rcnt_q == RCNT_LAST) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    ready_d      = 1'b1;
                    rcnt_d       = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                data_out_d = 1'b0;
                ready_d    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the line immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            led_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            rcnt_q       <= '0;
            tail_q       <= 1'b0;
            pix_addr_q   <= '0;
            data_out_q   <= 1'b0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            led_q        <= led_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            rcnt_q       <= rcnt_d;
            tail_q       <= tail_d;
            pix_addr_q   <= pix_addr_d;
            data_out_q   <= data_out_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_addr   = pix_addr_q;
    assign data_out   = data_out_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;

endmodule
